// File: rtl/tile_none_endpoint.sv
// tile_none_endpoint
// Self-contained endpoint for the router LOCAL port of a NONE tile.
// Incoming flits land in per-VC FIFOs with on-off backpressure toward the
// router. A round-robin, wormhole-locking arbiter drains them either into
// the void (sink mode) or back to the source tile (loopback mode).
//
// Arbiter states:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no packet in flight; any eligible VC may win, mode follows
//             | the loopback input
//   ST_LOCKED | HEAD popped from lock_vc_q; only that VC is eligible until
//             | its TAIL is popped; mode is frozen in mode_q
module tile_none_endpoint #(
    parameter int X_ADDR           = 0,
    parameter int Y_ADDR           = 0,
    parameter int VC_NUM           = 4,
    parameter int FIFO_DEPTH       = 8,
    parameter int ON_OFF_THRESHOLD = 2,
    parameter int X_W              = 2,
    parameter int Y_W              = 2,
    parameter int FLIT_W           = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              loopback,
    input  logic              router_flit_in_valid,
    input  logic [FLIT_W-1:0] router_flit_in,
    output logic [VC_NUM-1:0] ni_credit,
    output logic              ni_flit_out_valid,
    output logic [FLIT_W-1:0] ni_flit_out,
    input  logic [VC_NUM-1:0] router_credit,
    output logic [15:0]       pkt_count,
    output logic              overflow_err
);

    localparam int VC_W   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int VC_LSB = 2;
    localparam int DX_LSB = VC_LSB + VC_W;
    localparam int DY_LSB = DX_LSB + X_W;
    localparam int SX_LSB = DY_LSB + Y_W;
    localparam int SY_LSB = SX_LSB + X_W;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(FIFO_DEPTH - ON_OFF_THRESHOLD);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // FIFO storage and bookkeeping
    logic [FLIT_W-1:0] mem_q    [VC_NUM][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]  rd_ptr_q [VC_NUM];
    logic [CNT_W-1:0]  cnt_q    [VC_NUM];
    logic [CNT_W-1:0]  cnt_d    [VC_NUM];
    logic [VC_NUM-1:0] credit_q;
    logic              overflow_q;

    // Arbiter / egress state
    arb_state_e        state_q;
    logic [VC_W-1:0]   lock_vc_q;
    logic [VC_W-1:0]   rr_ptr_q;
    logic              mode_q;
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q;
    logic [15:0]       pkt_cnt_q;

    // Combinational decode
    logic [VC_W-1:0]   in_vc;
    logic [VC_NUM-1:0] push_req;
    logic [VC_NUM-1:0] push_ok;
    logic [VC_NUM-1:0] push_drop;
    logic [VC_NUM-1:0] elig;
    logic [VC_NUM-1:0] pop_hit;
    logic              mode_eff;
    logic              pop_valid;
    logic [VC_W-1:0]   pop_vc;
    logic [FLIT_W-1:0] pop_flit;
    logic [1:0]        pop_type;
    logic              pop_ends_pkt;
    logic [FLIT_W-1:0] lb_flit;
    logic [VC_W-1:0]   rr_next;

    assign in_vc = router_flit_in[VC_LSB +: VC_W];

    // Ingress decode: a push to a full FIFO is dropped even if that VC pops this cycle
    always_comb begin
        push_req  = '0;
        push_ok   = '0;
        push_drop = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            push_req[v]  = router_flit_in_valid && (in_vc == VC_W'(v));
            push_ok[v]   = push_req[v] && (cnt_q[v] != CNT_FULL);
            push_drop[v] = push_req[v] && (cnt_q[v] == CNT_FULL);
        end
    end

    // While locked, the mode captured at HEAD time governs the whole packet
    assign mode_eff = (state_q == ST_LOCKED) ? mode_q : loopback;

    // Per-VC eligibility: data present, drain enabled, router not stopping us, lock respected
    always_comb begin
        elig = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            elig[v] = (cnt_q[v] != '0) && enable
                      && !(mode_eff && router_credit[v])
                      && ((state_q == ST_IDLE) || (lock_vc_q == VC_W'(v)));
        end
    end

    // Round-robin pick, scanning upward from the pointer
    always_comb begin
        pop_valid = 1'b0;
        pop_vc    = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            if (!pop_valid && elig[VC_W'((int'(rr_ptr_q) + i) % VC_NUM)]) begin
                pop_valid = 1'b1;
                pop_vc    = VC_W'((int'(rr_ptr_q) + i) % VC_NUM);
            end
        end
    end

    assign pop_flit     = mem_q[pop_vc][rd_ptr_q[pop_vc]];
    assign pop_type     = pop_flit[1:0];
    assign pop_ends_pkt = (pop_type == T_TAIL) || (pop_type == T_HT);
    assign rr_next      = (int'(pop_vc) == VC_NUM - 1) ? '0 : pop_vc + 1'b1;

    // Loopback rewrite: route the head back to its source, stamp ourselves as source
    always_comb begin
        lb_flit = pop_flit;
        if ((pop_type == T_HEAD) || (pop_type == T_HT)) begin
            lb_flit[DX_LSB +: X_W] = pop_flit[SX_LSB +: X_W];
            lb_flit[DY_LSB +: Y_W] = pop_flit[SY_LSB +: Y_W];
            lb_flit[SX_LSB +: X_W] = X_W'(X_ADDR);
            lb_flit[SY_LSB +: Y_W] = Y_W'(Y_ADDR);
        end
    end

    // Next occupancy per VC; push and pop together leave the count unchanged
    always_comb begin
        pop_hit = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            pop_hit[v] = pop_valid && (pop_vc == VC_W'(v));
            cnt_d[v]   = cnt_q[v];
            if (push_ok[v] && !pop_hit[v]) begin
                cnt_d[v] = cnt_q[v] + 1'b1;
            end else if (!push_ok[v] && pop_hit[v]) begin
                cnt_d[v] = cnt_q[v] - 1'b1;
            end
        end
    end

    // FIFO storage writes; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (push_ok[v]) begin
                mem_q[v][wr_ptr_q[v]] <= router_flit_in;
            end
        end
    end

    // FIFO pointers, occupancy, on-off credit and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < VC_NUM; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
            credit_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (push_ok[v]) begin
                    wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
                end
                if (pop_hit[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
                end
                cnt_q[v]    <= cnt_d[v];
                credit_q[v] <= (cnt_d[v] >= CNT_STOP);
            end
            if (|push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Arbiter FSM with registered egress flit, RR pointer and packet counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lock_vc_q   <= '0;
            rr_ptr_q    <= '0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                mode_q <= loopback;
            end
            if (pop_valid) begin
                if (mode_eff) begin
                    out_valid_q <= 1'b1;
                    out_flit_q  <= lb_flit;
                end
                if (pop_ends_pkt) begin
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    rr_ptr_q  <= rr_next;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (pop_type == T_HEAD) begin
                            state_q   <= ST_LOCKED;
                            lock_vc_q <= pop_vc;
                        end
                    end
                    ST_LOCKED: begin
                        if (pop_ends_pkt) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ni_credit         = credit_q;
    assign ni_flit_out_valid = out_valid_q;
    assign ni_flit_out       = out_flit_q;
    assign pkt_count         = pkt_cnt_q;
    assign overflow_err      = overflow_q;

endmodule
